// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the instruction-fetch /
// load-store memory arbiter.
//   - arbState_e : transaction FSM states (IDLE, REQ, WAIT, RESP)
//   - owner_e    : which requester owns the outstanding transaction
//   - XLEN_DEFAULT / TIMEOUT_DEFAULT : parameter defaults for mem_arb
// XLEN normally comes from the project-wide defs.vh define; when that
// define is absent the datapath falls back to 64 bits.
`ifndef XLEN
`define XLEN 64
`endif

package mem_arb_pkg;

   localparam int XLEN_DEFAULT    = `XLEN;
   localparam int TIMEOUT_DEFAULT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } arbState_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant between the fetch (IF) and
// load/store (LS) requesters, with its own last-grant register.
//   clk, rst   : clock, asynchronous active-high reset
//   enable_i   : arbiter may grant this cycle (parent is idle)
//   reqIf_i    : fetch request valid
//   reqLs_i    : load/store request valid
//   gntIf_o    : fetch granted (doubles as its ready / acceptance)
//   gntLs_o    : load/store granted (doubles as its ready / acceptance)
// A grant is only ever given to a requester that is valid, so a grant is
// also the acceptance event and updates the last-grant register.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   input  logic reqIf_i,
   input  logic reqLs_i,
   output logic gntIf_o,
   output logic gntLs_o
);

   owner_e lastGrant_q;
   owner_e lastGrant_d;
   logic   pickLs;

   // On a tie the requester that did not win last time is chosen;
   // otherwise whichever side is asking wins.
   always_comb begin
      pickLs = reqLs_i;
      if (reqIf_i && reqLs_i) begin
         pickLs = (lastGrant_q == OWN_IF);
      end
   end

   assign gntLs_o = enable_i && reqLs_i && pickLs;
   assign gntIf_o = enable_i && reqIf_i && !pickLs;

   // Remember who was served so the next tie goes the other way.
   always_comb begin
      lastGrant_d = lastGrant_q;
      if (gntLs_o) begin
         lastGrant_d = OWN_LS;
      end else if (gntIf_o) begin
         lastGrant_d = OWN_IF;
      end
   end

   // Reset to IF so load/store wins the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrant_q <= OWN_IF;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between an instruction-fetch port and a
// load/store port, with exactly one transaction outstanding at a time.
//   clk, rst             : clock, asynchronous active-high reset
//   if_req_*  / if_rsp_* : fetch request handshake and response
//   ls_req_*  / ls_rsp_* : load/store request handshake and response
//   mem_req_* / mem_rsp_*: shared memory request handshake and response
// Parameters: XLEN (address/data width), TIMEOUT (max WAIT cycles before
// an error response is forced).
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [XLEN-1:0]   if_req_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_inst,
   output logic              if_rsp_err,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_req_we,
   input  logic [XLEN-1:0]   ls_req_addr,
   input  logic [XLEN-1:0]   ls_req_wdata,
   input  logic [XLEN/8-1:0] ls_req_wstrb,
   output logic              ls_rsp_valid,
   output logic [XLEN-1:0]   ls_rsp_rdata,
   output logic              ls_rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   arbState_e         state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN/8-1:0] wstrb_q, wstrb_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CW-1:0]     waitCnt_q, waitCnt_d;

   logic arbEnable;
   logic gntIf;
   logic gntLs;
   logic accept;
   logic timedOut;

   // Readies are forced low while reset is held so every output is zero.
   assign arbEnable = (state_q == ST_IDLE) && !rst;
   assign accept    = gntIf || gntLs;
   assign timedOut  = (waitCnt_q == LAST_WAIT);

   rr_arb2 u_rrArb (
      .clk      (clk),
      .rst      (rst),
      .enable_i (arbEnable),
      .reqIf_i  (if_req_valid),
      .reqLs_i  (ls_req_valid),
      .gntIf_o  (gntIf),
      .gntLs_o  (gntLs)
   );

   // State register plus the transaction/response holding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_IF;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Next-state: memory response wins over a timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)                     state_d = ST_REQ;
         ST_REQ:  if (mem_req_ready)              state_d = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid || timedOut)  state_d = ST_RESP;
         ST_RESP:                                 state_d = ST_IDLE;
         default:                                 state_d = ST_IDLE;
      endcase
   end

   // Capture the accepted request in IDLE and the memory result in WAIT.
   // A fetch is a full-width read, so it records we=0 and all strobes set.
   always_comb begin
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      waitCnt_d = waitCnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gntLs) begin
               owner_d = OWN_LS;
               we_d    = ls_req_we;
               addr_d  = ls_req_addr;
               wdata_d = ls_req_wdata;
               wstrb_d = ls_req_wstrb;
            end else if (gntIf) begin
               owner_d = OWN_IF;
               we_d    = 1'b0;
               addr_d  = if_req_addr;
               wdata_d = '0;
               wstrb_d = '1;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               waitCnt_d = '0;
            end
         end
         ST_WAIT: begin
            waitCnt_d = waitCnt_q + CW'(1);
            if (mem_rsp_valid) begin
               rdata_d = mem_rsp_rdata;
               err_d   = 1'b0;
            end else if (timedOut) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Handshake outputs decoded from the current state and owner.
   always_comb begin
      mem_req_valid = (state_q == ST_REQ);
      if_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_IF);
      ls_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_LS);
   end

   assign if_req_ready  = gntIf;
   assign ls_req_ready  = gntLs;
   assign mem_req_we    = we_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;
   assign ls_rsp_rdata  = rdata_q;
   assign ls_rsp_err    = err_q;
   assign if_rsp_err    = err_q;

   // Fetch returns the 32-bit word selected by address bit 2.
   if (XLEN >= 64) begin : g_wideInst
      assign if_rsp_inst = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
   end else begin : g_narrowInst
      assign if_rsp_inst = rdata_q[31:0];
   end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb (XLEN=64, TIMEOUT=8).
// A transaction-level reference model checks the DUT every cycle; directed
// scenarios add literal expectations for fetch, tie alternation, stalled
// store, timeout and reset abandonment, followed by a randomized phase.
module tb_mem_arb;

   localparam int XLEN = 64;
   localparam int TMO  = 8;
   localparam int SW   = XLEN / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            if_req_valid, if_req_ready;
   logic [XLEN-1:0] if_req_addr;
   logic            if_rsp_valid, if_rsp_err;
   logic [31:0]     if_rsp_inst;
   logic            ls_req_valid, ls_req_ready, ls_req_we;
   logic [XLEN-1:0] ls_req_addr, ls_req_wdata;
   logic [SW-1:0]   ls_req_wstrb;
   logic            ls_rsp_valid, ls_rsp_err;
   logic [XLEN-1:0] ls_rsp_rdata;
   logic            mem_req_valid, mem_req_ready, mem_req_we;
   logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
   logic [SW-1:0]   mem_req_wstrb;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;

   int compared   = 0;
   int mismatched = 0;

   mem_arb #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_req_valid  (if_req_valid),
      .if_req_ready  (if_req_ready),
      .if_req_addr   (if_req_addr),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_inst   (if_rsp_inst),
      .if_rsp_err    (if_rsp_err),
      .ls_req_valid  (ls_req_valid),
      .ls_req_ready  (ls_req_ready),
      .ls_req_we     (ls_req_we),
      .ls_req_addr   (ls_req_addr),
      .ls_req_wdata  (ls_req_wdata),
      .ls_req_wstrb  (ls_req_wstrb),
      .ls_rsp_valid  (ls_rsp_valid),
      .ls_rsp_rdata  (ls_rsp_rdata),
      .ls_rsp_err    (ls_rsp_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkQuiet(input string name);
      checkOutput({name, "_ctrl"},
                  64'({if_req_ready, ls_req_ready, mem_req_valid, mem_req_we,
                       if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err}), 64'd0);
      checkOutput({name, "_data"},
                  mem_req_addr | mem_req_wdata | ls_rsp_rdata |
                  {32'd0, if_rsp_inst} | {56'd0, mem_req_wstrb}, 64'd0);
   endtask

   // Reference model: one outstanding transaction described by a few flags
   // (busy / issued to memory / response due) plus the captured request.
   bit              mBusy = 1'b0, mIssued = 1'b0, mRespDue = 1'b0;
   bit              mLastLs = 1'b0, mOwnLs = 1'b0, mWe = 1'b0, mErr = 1'b0;
   logic [63:0]     mAddr = '0, mWdata = '0, mRdata = '0;
   logic [SW-1:0]   mWstrb = '0;
   int              mWaited = 0;

   // Compare process: inputs change just after the rising edge, so the
   // falling edge sees the same inputs the next rising edge will consume.
   always @(negedge clk) begin : compareProc
      bit pickLs, idleNow, expIfRdy, expLsRdy, expMemValid;
      logic [31:0] expInst;
      if (rst) begin
         mBusy = 1'b0; mIssued = 1'b0; mRespDue = 1'b0; mLastLs = 1'b0;
         checkQuiet("in_reset");
      end else begin
         pickLs   = (if_req_valid && ls_req_valid) ? !mLastLs : ls_req_valid;
         idleNow  = !mBusy && !mRespDue;
         expLsRdy = idleNow && ls_req_valid && pickLs;
         expIfRdy = idleNow && if_req_valid && !pickLs;
         expMemValid = mBusy && !mIssued;
         checkOutput("if_req_ready", 64'(if_req_ready), 64'(expIfRdy));
         checkOutput("ls_req_ready", 64'(ls_req_ready), 64'(expLsRdy));
         checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(expMemValid));
         if (expMemValid) begin
            checkOutput("mem_req_addr", mem_req_addr, mAddr);
            checkOutput("mem_req_we", 64'(mem_req_we), 64'(mWe));
            checkOutput("mem_req_wstrb", 64'(mem_req_wstrb), 64'(mWstrb));
            if (mWe) checkOutput("mem_req_wdata", mem_req_wdata, mWdata);
         end
         checkOutput("if_rsp_valid", 64'(if_rsp_valid), 64'(mRespDue && !mOwnLs));
         checkOutput("ls_rsp_valid", 64'(ls_rsp_valid), 64'(mRespDue && mOwnLs));
         if (mRespDue && mOwnLs) begin
            checkOutput("ls_rsp_rdata", ls_rsp_rdata, mRdata);
            checkOutput("ls_rsp_err", 64'(ls_rsp_err), 64'(mErr));
         end
         if (mRespDue && !mOwnLs) begin
            expInst = mAddr[2] ? mRdata[63:32] : mRdata[31:0];
            checkOutput("if_rsp_inst", 64'(if_rsp_inst), 64'(expInst));
            checkOutput("if_rsp_err", 64'(if_rsp_err), 64'(mErr));
         end
         // Advance the model by one cycle.
         if (mRespDue) begin
            mRespDue = 1'b0;
         end else if (!mBusy) begin
            if (expLsRdy || expIfRdy) begin
               mBusy   = 1'b1;
               mIssued = 1'b0;
               mOwnLs  = expLsRdy;
               mLastLs = expLsRdy;
               mAddr   = expLsRdy ? ls_req_addr : if_req_addr;
               mWe     = expLsRdy ? ls_req_we : 1'b0;
               mWdata  = ls_req_wdata;
               mWstrb  = expLsRdy ? ls_req_wstrb : '1;
            end
         end else if (!mIssued) begin
            if (mem_req_ready) begin
               mIssued = 1'b1;
               mWaited = 0;
            end
         end else if (mem_rsp_valid) begin
            mRdata = mem_rsp_rdata; mErr = 1'b0; mBusy = 1'b0; mRespDue = 1'b1;
         end else if (mWaited == TMO - 1) begin
            mRdata = '0; mErr = 1'b1; mBusy = 1'b0; mRespDue = 1'b1;
         end else begin
            mWaited++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
      ls_req_wdata = '0; ls_req_wstrb = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Lets any in-flight transaction finish with an always-ready memory.
   task automatic drain();
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
      repeat (6) tick();
      clearInputs();
      tick();
   endtask

   // Fetch at 0x80000004 answered on the third WAIT cycle.
   task automatic applyStimulusFetch();
      clearInputs();
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0004; mem_req_ready = 1'b1;
      #1 checkOutput("t27_if_ready", 64'(if_req_ready), 64'd1);
      tick();
      if_req_valid = 1'b0;
      #1;
      checkOutput("t27_mem_valid", 64'(mem_req_valid), 64'd1);
      checkOutput("t27_mem_addr", mem_req_addr, 64'h8000_0004);
      checkOutput("t27_mem_wstrb", 64'(mem_req_wstrb), 64'hFF);
      tick();
      mem_req_ready = 1'b0;
      tick();
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checkOutput("t27_rsp_valid", 64'(if_rsp_valid), 64'd1);
      checkOutput("t27_inst", 64'(if_rsp_inst), 64'h1111_2222);
      checkOutput("t27_err", 64'(if_rsp_err), 64'd0);
      checkOutput("t27_ls_quiet", 64'(ls_rsp_valid), 64'd0);
      tick();
      #1 checkOutput("t27_pulse_end", 64'(if_rsp_valid), 64'd0);
   endtask

   // Persistent ties from reset must be granted LS, IF, LS.
   task automatic applyStimulusTies();
      bit expOrder [3] = '{1'b1, 1'b0, 1'b1};
      bit gotOrder [3] = '{1'b0, 1'b0, 1'b0};
      int n = 0;
      doReset();
      if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0100;
      if_req_addr = 64'h8000_0200; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
      for (int c = 0; c < 40 && n < 3; c++) begin
         #1;
         if (ls_req_ready) begin gotOrder[n] = 1'b1; n++; end
         else if (if_req_ready) begin gotOrder[n] = 1'b0; n++; end
         tick();
      end
      checkOutput("t28_grant_count", 64'(n), 64'd3);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("t28_grant%0d_is_ls", i), 64'(gotOrder[i]), 64'(expOrder[i]));
      drain();
   endtask

   // Store held by a memory that is not ready for four cycles.
   task automatic applyStimulusStore();
      int hs = 0, reqCycles = 0, rspCount = 0;
      clearInputs();
      ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 64'h8000_1000;
      ls_req_wdata = 64'hDEAD_BEEF; ls_req_wstrb = 8'h0F;
      tick();
      ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '1;
      ls_req_wdata = '1; ls_req_wstrb = '1;
      for (int c = 0; c < 10; c++) begin
         mem_req_ready = (c >= 4);
         mem_rsp_valid = (c == 6);
         mem_rsp_rdata = 64'h5555;
         #1;
         if (mem_req_valid) begin
            reqCycles++;
            checkOutput("t29_hold", {mem_req_addr[31:0], mem_req_wdata[31:0]},
                        64'h8000_1000_DEAD_BEEF);
            checkOutput("t29_hold_ctl", 64'({mem_req_we, mem_req_wstrb}), 64'h10F);
            if (mem_req_ready) hs++;
         end
         if (ls_rsp_valid) begin
            rspCount++;
            checkOutput("t29_err", 64'(ls_rsp_err), 64'd0);
         end
         tick();
      end
      checkOutput("t29_handshakes", 64'(hs), 64'd1);
      checkOutput("t29_req_cycles", 64'(reqCycles), 64'd5);
      checkOutput("t29_rsp_count", 64'(rspCount), 64'd1);
      clearInputs();
   endtask

   // Load with no memory answer must time out eight cycles into WAIT.
   task automatic applyStimulusTimeout();
      int n = 0;
      bit seen = 1'b0;
      clearInputs();
      ls_req_valid = 1'b1; ls_req_addr = 64'h8000_2000; mem_req_ready = 1'b1;
      tick();
      ls_req_valid = 1'b0;
      tick();
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (ls_rsp_valid) begin
            seen = 1'b1;
            checkOutput("t30_err", 64'(ls_rsp_err), 64'd1);
            checkOutput("t30_rdata", ls_rsp_rdata, 64'd0);
         end else begin
            tick();
            n++;
         end
      end
      checkOutput("t30_latency", 64'(n), 64'd8);
      tick();
      clearInputs();
   endtask

   // Stray response in IDLE, reset during WAIT, then a clean fetch.
   task automatic applyStimulusResetMid();
      clearInputs();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hBAD0_BAD0;
      #1 checkOutput("t31_stray_idle", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
      tick();
      mem_rsp_valid = 1'b0;
      #1 checkOutput("t31_stray_after", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
      ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3000; mem_req_ready = 1'b1;
      tick();
      ls_req_valid = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1 checkQuiet("t31_async");
      @(posedge clk);
      #1 rst = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hBAD1_BAD1;
      #1 checkOutput("t31_post_rst", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
      tick();
      mem_rsp_valid = 1'b0;
      #1 checkOutput("t31_post_rst2", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0010; mem_req_ready = 1'b1;
      tick();
      if_req_valid = 1'b0;
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checkOutput("t31_next_valid", 64'(if_rsp_valid), 64'd1);
      checkOutput("t31_next_inst", 64'(if_rsp_inst), 64'hCCCC_DDDD);
      tick();
      clearInputs();
   endtask

   // Randomized traffic with occasional reset pulses.
   task automatic applyStimulusRandom(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         rst           = ($urandom_range(0, 399) == 0);
         if_req_valid  = ($urandom_range(0, 2) != 0);
         if_req_addr   = {$urandom, $urandom};
         ls_req_valid  = ($urandom_range(0, 2) != 0);
         ls_req_we     = $urandom_range(0, 1) == 1;
         ls_req_addr   = {$urandom, $urandom};
         ls_req_wdata  = {$urandom, $urandom};
         ls_req_wstrb  = SW'($urandom);
         mem_req_ready = ($urandom_range(0, 2) != 0);
         mem_rsp_valid = ($urandom_range(0, 5) == 0);
         mem_rsp_rdata = {$urandom, $urandom};
         tick();
      end
      rst = 1'b0;
      clearInputs();
      tick();
   endtask

   initial begin
      clearInputs();
      #1 rst = 1'b1;
      repeat (3) tick();
      checkQuiet("reset_state");
      rst = 1'b0;
      applyStimulusFetch();
      applyStimulusTies();
      applyStimulusStore();
      applyStimulusTimeout();
      applyStimulusResetMid();
      applyStimulusRandom(2500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter XLEN, default `XLEN (64), SHALL set address/data width.
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the maximum number of WAIT cycles before a response is forced.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 RST  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 if_req_valid/if_req_ready  in/out  1/1  SHALL form the instruction-fetch request handshake; if_req_addr  in  XLEN.
REQ-006 if_rsp_valid  out  1, if_rsp_inst  out  32, if_rsp_err  out  1  SHALL carry the fetch response.
REQ-007 ls_req_valid/ls_req_ready  in/out  1/1, ls_req_we  in  1, ls_req_addr  in  XLEN, ls_req_wdata  in  XLEN, ls_req_wstrb  in  XLEN/8  SHALL form the load/store request.
REQ-008 ls_rsp_valid  out  1, ls_rsp_rdata  out  XLEN, ls_rsp_err  out  1  SHALL carry the load/store response.
REQ-009 mem_req_valid/mem_req_ready  out/in  1/1, mem_req_we  out  1, mem_req_addr  out  XLEN, mem_req_wdata  out  XLEN, mem_req_wstrb  out  XLEN/8  SHALL drive the shared memory port.
REQ-010 mem_rsp_valid  in  1, mem_rsp_rdata  in  XLEN  SHALL return memory responses.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-012 IDLE: if_req_ready/ls_req_ready SHALL be high only for the granted requester, combinationally from valids and last_grant; all other states drive both readies low.
REQ-013 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; when one is valid, grant it; last_grant updates on acceptance.
REQ-014 On acceptance in IDLE, owner, we, addr, wdata, wstrb SHALL be registered and FSM SHALL go to REQ; a fetch registers we=0 and wstrb=all-ones.
REQ-015 REQ: mem_req_valid SHALL be high with registered fields stable until mem_req_ready is sampled high, then go to WAIT; latency from acceptance to mem_req_valid is 1 cycle.
REQ-016 WAIT: a wait counter SHALL clear on entry and increment each cycle; mem_rsp_valid captures rdata, err=0, goes to RESP.
REQ-017 WAIT: counter reaching TIMEOUT-1 without mem_rsp_valid SHALL capture rdata=0, err=1, go to RESP.
REQ-018 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-019 RESP: the owner's rsp_valid SHALL be high for exactly one cycle with registered data/err, then go to IDLE; the other requester's rsp_valid stays low.
REQ-020 if_rsp_inst SHALL be rdata[63:32] when registered addr[2]=1, else rdata[31:0].
REQ-021 Response-to-next-acceptance SHALL take one cycle (IDLE after RESP); no new request is accepted in RESP.
REQ-022 Requests deasserted before acceptance SHALL be dropped without state change.

Reset
REQ-023 RST high SHALL, asynchronously, force state IDLE, last_grant=IF (so LS wins the first tie), wait counter 0, and all outputs 0.
REQ-024 RST mid-transaction SHALL abandon it with no response issued; memory responses after reset release are ignored per REQ-018.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the state enum, the owner enum (OWN_IF, OWN_LS), and the TIMEOUT default; XLEN comes from defs.vh.
REQ-026 Sub-module rr_arb2 (2-way round-robin grant with last_grant register) SHALL be instantiated once.

Verification
REQ-027 Fetch only: if_req addr=0x80000004, memory rdata=0x1111_2222_3333_4444 after 3 WAIT cycles -> if_rsp_inst=0x11112222, err=0, one-cycle pulse.
REQ-028 Simultaneous valids from reset -> LS granted first, then IF; repeated ties alternate LS, IF, LS.
REQ-029 Store: we=1, addr=0x80001000, wdata=0xDEADBEEF, wstrb=0x0F, mem_req_ready low 4 cycles -> fields held stable, exactly one handshake.
REQ-030 TIMEOUT=8, no mem_rsp_valid -> ls_rsp_valid with err=1, rdata=0 eight cycles after entering WAIT.
REQ-031 Stray mem_rsp_valid in IDLE, then RST asserted during WAIT -> no rsp_valid pulses; all outputs 0 immediately; next request serviced normally.
